lsu_mem_master: RTL and testbench

Load/store unit that drives the data-side port of the core's unified memory model. It accepts one load or store request at a time from the execute stage. Loads are issued as word reads and the addressed byte or halfword is extracted and sign/zero-extended. Byte and halfword stores are carried out as read-modify-write sequences, because the memory always writes four bytes per write strobe.

---
 rtl/lsu_mem_master.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit driving the data-side port of the unified memory model.
// Loads are word reads with byte/half extraction and sign/zero extension.
// Byte and half stores are read-modify-write because the memory always
// commits four bytes per write.
module lsu_mem_master #(
  parameter logic [31:0] RAM_ORI = 32'h0020_0000,
  parameter logic [31:0] RAM_LEN = 32'h0010_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        ram_rd_en_o,
  output logic [31:0] ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        ram_wr_en_o,
  output logic [31:0] ram_wr_addr_o,
  output logic [31:0] ram_wr_data_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [32:0] WIN_END = {1'b0, RAM_ORI} + {1'b0, RAM_LEN};

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] f_access_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Load data always starts at bit 0 because the memory returns bytes from addr.
  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    logic [31:0] v;
    case (sz)
      2'b00:   v = {{24{d[7] & ~uns}}, d[7:0]};
      2'b01:   v = {{16{d[15] & ~uns}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  // Upper bytes come back from the read so the write rewrites them unchanged.
  function automatic logic [31:0] f_merge(input logic [31:0] rd, input logic [15:0] wd,
                                          input logic [1:0] sz);
    logic [31:0] v;
    if (sz == 2'b00) v = {rd[31:8], wd[7:0]};
    else             v = {rd[31:16], wd[15:0]};
    return v;
  endfunction

  logic [1:0]  r_state;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_rd_en;
  logic [31:0] r_rd_addr;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [15:0] r_wdata_lo;

  logic        w_accept;
  logic [2:0]  w_bytes;
  logic [32:0] w_end;
  logic        w_req_err;
  logic        w_needs_read;

  assign w_accept     = req_valid_i & r_ready;
  assign w_bytes      = f_access_bytes(req_size_i);
  assign w_end        = {1'b0, req_addr_i} + {30'd0, w_bytes};
  assign w_req_err    = (req_size_i == 2'b11)
                      | ((req_size_i == 2'b01) & req_addr_i[0])
                      | ((req_size_i == 2'b10) & (req_addr_i[1:0] != 2'b00))
                      | (req_addr_i < RAM_ORI)
                      | (w_end > WIN_END);
  assign w_needs_read = ~req_we_i | (req_size_i != 2'b10);

  assign req_ready_o   = r_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign ram_rd_en_o   = r_rd_en;
  assign ram_rd_addr_o = r_rd_addr;
  assign ram_wr_en_o   = r_wr_en;
  assign ram_wr_addr_o = r_wr_addr;
  assign ram_wr_data_o = r_wr_data;

  // Latch the request fields at the accepting edge; they are only read after it.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_we       <= req_we_i;
      r_size     <= req_size_i;
      r_unsigned <= req_unsigned_i;
      r_addr     <= req_addr_i;
      r_wdata_lo <= req_wdata_i[15:0];
    end
  end

  // Request sequencer: IDLE -> (READ) -> (WRITE) -> RESP, all outputs registered.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            if (w_req_err) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (w_needs_read) begin
              r_state   <= ST_READ;
              r_rd_en   <= 1'b1;
              r_rd_addr <= req_addr_i;
            end else begin
              r_state   <= ST_WRITE;
              r_wr_en   <= 1'b1;
              r_wr_addr <= req_addr_i;
              r_wr_data <= req_wdata_i;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        ST_READ: begin
          r_rd_en <= 1'b0;
          if (r_we) begin
            r_state   <= ST_WRITE;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= f_merge(ram_rd_data_i, r_wdata_lo, r_size);
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= f_extend(ram_rd_data_i, r_size, r_unsigned);
          end
        end
        ST_WRITE: begin
          r_wr_en     <= 1'b0;
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: byte-addressed memory model on the RAM port,
// directed scenarios plus randomized transactions against a reference model.
module tb_lsu_mem_master;

  localparam logic [31:0] ORI = 32'h0020_0000;
  localparam logic [31:0] LEN = 32'h0010_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        ram_rd_en_o;
  logic [31:0] ram_rd_addr_o;
  logic [31:0] ram_rd_data_i;
  logic        ram_wr_en_o;
  logic [31:0] ram_wr_addr_o;
  logic [31:0] ram_wr_data_o;

  always #5 clk_i = ~clk_i;

  lsu_mem_master #(.RAM_ORI(ORI), .RAM_LEN(LEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        both;
    logic        busy_rdy;
    logic        pulse_ok;
    logic        to;
  } res_t;

  int n_assert;
  int n_fail;
  int rsp_cnt;
  int wr_cnt;

  logic [7:0] tmem    [0:4095];
  logic [7:0] ref_mem [0:4095];

  function automatic int midx(input logic [31:0] a, input int k);
    logic [31:0] o;
    o = (a - ORI + 32'(k)) & 32'h0000_0FFF;
    return int'(o);
  endfunction

  // Memory seen by the DUT: combinational read, 4-byte write at the rising edge.
  always_comb begin
    ram_rd_data_i = '0;
    for (int k = 0; k < 4; k++) ram_rd_data_i[8*k +: 8] = tmem[midx(ram_rd_addr_o, k)];
  end

  initial for (int i = 0; i < 4096; i++) tmem[i] <= 8'h00;

  always @(posedge clk_i) begin
    if (ram_wr_en_o)
      for (int k = 0; k < 4; k++) tmem[midx(ram_wr_addr_o, k)] <= ram_wr_data_o[8*k +: 8];
  end

  always @(posedge clk_i) begin
    if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
    if (ram_wr_en_o) wr_cnt  <= wr_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic res_t res_clear();
    res_t r;
    r.rdata = '0; r.err = 1'b0; r.lat = 0; r.nrd = 0; r.nwr = 0;
    r.raddr = '0; r.waddr = '0; r.wdata = '0;
    r.both = 1'b0; r.busy_rdy = 1'b0; r.pulse_ok = 1'b0; r.to = 1'b0;
    return r;
  endfunction

  // Reference model: byte-array memory and the architectural load/store rules.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, output res_t e);
    longint nb, x;
    logic [31:0] v;
    e = res_clear();
    nb = 4;
    if (sz == 2'b11) e.err = 1'b1;
    else begin
      nb = longint'(1) << sz;
      e.err = ((longint'(a) % nb) != 0) || (a < ORI) ||
              (longint'(a) + nb > longint'(ORI) + longint'(LEN));
    end
    if (e.err) e.lat = 1;
    else if (!we) begin
      v = {ref_mem[midx(a, 3)], ref_mem[midx(a, 2)], ref_mem[midx(a, 1)], ref_mem[midx(a, 0)]};
      if (sz == 2'b00) begin
        x = longint'(v[7:0]);
        if (!uns && x > 127) x = x - 256;
      end else if (sz == 2'b01) begin
        x = longint'(v[15:0]);
        if (!uns && x > 32767) x = x - 65536;
      end else x = longint'(v);
      e.rdata = x[31:0]; e.lat = 2; e.nrd = 1; e.raddr = a;
    end else begin
      for (int i = 0; i < int'(nb); i++) ref_mem[midx(a, i)] = wd[8*i +: 8];
      e.wdata = {ref_mem[midx(a, 3)], ref_mem[midx(a, 2)], ref_mem[midx(a, 1)], ref_mem[midx(a, 0)]};
      e.waddr = a; e.nwr = 1;
      e.nrd = (nb == 4) ? 0 : 1;
      e.lat = (nb == 4) ? 2 : 3;
      e.raddr = a;
    end
  endtask

  // Drive one request and record what the DUT does until its response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output res_t r);
    int w;
    r = res_clear();
    w = 0;
    while (req_ready_o !== 1'b1 && w < 20) begin @(posedge clk_i); #1; w++; end
    req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_we_i = 1'($urandom); req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
    req_addr_i = $urandom; req_wdata_i = $urandom;
    r.to = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (req_ready_o) r.busy_rdy = 1'b1;
      if (ram_rd_en_o) begin r.nrd++; r.raddr = ram_rd_addr_o; end
      if (ram_wr_en_o) begin r.nwr++; r.waddr = ram_wr_addr_o; r.wdata = ram_wr_data_o; end
      if (ram_rd_en_o && ram_wr_en_o) r.both = 1'b1;
      if (rsp_valid_o) begin
        r.lat = k; r.rdata = rsp_rdata_o; r.err = rsp_err_o; r.to = 1'b0;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (!r.to) begin
      @(posedge clk_i); #1;
      r.pulse_ok = (rsp_valid_o === 1'b0) && (req_ready_o === 1'b1) && (rsp_err_o === 1'b0);
    end
  endtask

  task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, output res_t r, output res_t e);
    model(we, sz, uns, a, wd, e);
    do_req(we, sz, uns, a, wd, r);
  endtask

  task automatic test_reset;
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    #1 rst_i = 1'b0;
    #1;
    n_assert++;
    if ({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ram_rd_en_o, ram_rd_addr_o,
         ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero (ready=%b rd_en=%b wr_en=%b), required all 0",
                         req_ready_o, ram_rd_en_o, ram_wr_en_o);
    end
    req_valid_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_assert++;
    if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_ready: ready=%b rsp_valid=%b, required 0/0", req_ready_o, rsp_valid_o);
    end
    req_valid_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_assert++;
    if (req_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: ready=%b, required 0", req_ready_o);
    end
    @(posedge clk_i); #1;
    n_assert++;
    if (req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_first_edge: ready=%b, required 1", req_ready_o);
    end
  endtask

  task automatic test_extension;
    res_t r, e;
    logic [1:0]  sz_t [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad_t [4] = '{32'h0020_0010, 32'h0020_0010, 32'h0020_0010, 32'h0020_0012};
    logic [31:0] ex_t [4] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'h0000_43F1, 32'hFFFF_8765};
    xact(1'b1, 2'b10, 1'b0, 32'h0020_0010, 32'h8765_43F1, r, e);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, sz_t[i], un_t[i], ad_t[i], 32'h0, r, e);
      n_assert++;
      if (r.rdata !== ex_t[i] || r.err !== 1'b0) begin
        n_fail++; $display("FAIL ext_data[%0d]: rdata=%h err=%b, required %h err=0", i, r.rdata, r.err, ex_t[i]);
      end
      n_assert++;
      if (r.lat != 2 || r.nrd != 1 || r.nwr != 0 || r.raddr !== ad_t[i] || !r.pulse_ok || r.busy_rdy) begin
        n_fail++; $display("FAIL ext_timing[%0d]: lat=%0d nrd=%0d nwr=%0d raddr=%h, required 2/1/0/%h",
                           i, r.lat, r.nrd, r.nwr, r.raddr, ad_t[i]);
      end
    end
  endtask

  task automatic test_rmw;
    res_t r, e;
    xact(1'b1, 2'b10, 1'b0, 32'h0020_0020, 32'h1122_3344, r, e);
    xact(1'b1, 2'b00, 1'b0, 32'h0020_0020, 32'h1234_56AB, r, e);
    n_assert++;
    if (r.lat != 3 || r.nrd != 1 || r.nwr != 1 || r.both || r.wdata !== 32'h1122_33AB ||
        r.waddr !== 32'h0020_0020 || r.rdata !== 32'h0 || r.err !== 1'b0 || !r.pulse_ok) begin
      n_fail++; $display("FAIL sb_rmw: lat=%0d nrd=%0d nwr=%0d wdata=%h waddr=%h, required 3/1/1/112233ab/00200020",
                         r.lat, r.nrd, r.nwr, r.wdata, r.waddr);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h0020_0020, 32'h0, r, e);
    n_assert++;
    if (r.rdata !== 32'h1122_33AB) begin
      n_fail++; $display("FAIL sb_readback: rdata=%h, required 112233ab", r.rdata);
    end
    xact(1'b1, 2'b01, 1'b0, 32'h0020_0020, 32'h9999_BEEF, r, e);
    n_assert++;
    if (r.lat != 3 || r.nrd != 1 || r.nwr != 1 || r.wdata !== 32'h1122_BEEF) begin
      n_fail++; $display("FAIL sh_rmw: lat=%0d nrd=%0d nwr=%0d wdata=%h, required 3/1/1/1122beef",
                         r.lat, r.nrd, r.nwr, r.wdata);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h0020_0020, 32'h0, r, e);
    n_assert++;
    if (r.rdata !== 32'h1122_BEEF) begin
      n_fail++; $display("FAIL sh_readback: rdata=%h, required 1122beef", r.rdata);
    end
  endtask

  task automatic test_word_store;
    res_t r, e;
    xact(1'b1, 2'b10, 1'b0, 32'h0020_0040, 32'hDEAD_BEEF, r, e);
    n_assert++;
    if (r.lat != 2 || r.nrd != 0 || r.nwr != 1 || r.wdata !== 32'hDEAD_BEEF ||
        r.waddr !== 32'h0020_0040 || r.rdata !== 32'h0 || !r.pulse_ok) begin
      n_fail++; $display("FAIL sw: lat=%0d nrd=%0d nwr=%0d wdata=%h, required 2/0/1/deadbeef",
                         r.lat, r.nrd, r.nwr, r.wdata);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h0020_0040, 32'h0, r, e);
    n_assert++;
    if (r.rdata !== 32'hDEAD_BEEF || r.lat != 2) begin
      n_fail++; $display("FAIL sw_readback: rdata=%h lat=%0d, required deadbeef/2", r.rdata, r.lat);
    end
  endtask

  task automatic test_errors;
    res_t r, e;
    logic        we_t [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz_t [9] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [31:0] ad_t [9] = '{32'h0020_0002, 32'h0020_0001, 32'h001F_FFFF, 32'h0030_0000,
                              32'h0020_0000, 32'h0030_0000, 32'h002F_FFFC, 32'h002F_FFFF, 32'h002F_FFFE};
    logic        er_t [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      xact(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hA5A5_5A5A, r, e);
      n_assert++;
      if (r.err !== er_t[i] || (er_t[i] && (r.lat != 1 || r.nrd != 0 || r.nwr != 0 || r.rdata !== 32'h0)) ||
          (!er_t[i] && (r.lat != 2 || r.rdata !== e.rdata)) || !r.pulse_ok) begin
        n_fail++; $display("FAIL err_case[%0d]: err=%b lat=%0d nrd=%0d nwr=%0d rdata=%h, required err=%b",
                           i, r.err, r.lat, r.nrd, r.nwr, r.rdata, er_t[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic        we_a [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz_a [4] = '{2'b10, 2'b00, 2'b00, 2'b10};
    logic [31:0] a_a  [4] = '{32'h0020_0100, 32'h0020_0101, 32'h0020_0102, 32'h0020_0100};
    logic [31:0] wd_a [4] = '{32'hCAFE_F00D, 32'h0, 32'h0000_005A, 32'h0};
    res_t e [4];
    int acc_n, rsp_n;
    logic busy, acc, prev_rsp;
    for (int i = 0; i < 4; i++) model(we_a[i], sz_a[i], 1'b0, a_a[i], wd_a[i], e[i]);
    acc_n = 0; rsp_n = 0; busy = 1'b0; prev_rsp = 1'b0;
    req_we_i = we_a[0]; req_size_i = sz_a[0]; req_unsigned_i = 1'b0;
    req_addr_i = a_a[0]; req_wdata_i = wd_a[0]; req_valid_i = 1'b1;
    for (int c = 0; c < 60 && rsp_n < 4; c++) begin
      acc = req_valid_i && req_ready_o;
      @(posedge clk_i); #1;
      if (acc) begin
        acc_n++; busy = 1'b1;
        if (acc_n < 4) begin
          req_we_i = we_a[acc_n]; req_size_i = sz_a[acc_n];
          req_addr_i = a_a[acc_n]; req_wdata_i = wd_a[acc_n];
        end else req_valid_i = 1'b0;
      end
      if (prev_rsp) begin
        n_assert++;
        if (req_ready_o !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready_rise: ready=%b after RESP, required 1", req_ready_o);
        end
      end
      if (busy) begin
        n_assert++;
        if (req_ready_o !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ready_busy: ready=%b while busy (req %0d), required 0", req_ready_o, acc_n);
        end
      end
      prev_rsp = 1'b0;
      if (rsp_valid_o) begin
        n_assert++;
        if (rsp_n >= acc_n || rsp_rdata_o !== e[rsp_n].rdata || rsp_err_o !== e[rsp_n].err) begin
          n_fail++; $display("FAIL b2b_rsp[%0d]: rdata=%h err=%b, required %h err=%b",
                             rsp_n, rsp_rdata_o, rsp_err_o, e[rsp_n].rdata, e[rsp_n].err);
        end
        rsp_n++; busy = 1'b0; prev_rsp = 1'b1;
      end
    end
    req_valid_i = 1'b0;
    n_assert++;
    if (acc_n != 4 || rsp_n != 4) begin
      n_fail++; $display("FAIL b2b_count: accepted=%0d responses=%0d, required 4/4", acc_n, rsp_n);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_rmw;
    res_t r, e;
    int rsp0, wr0;
    xact(1'b1, 2'b10, 1'b0, 32'h0020_0080, 32'h5566_7788, r, e);
    rsp0 = rsp_cnt; wr0 = wr_cnt;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0020_0080; req_wdata_i = 32'h0000_00AB;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    n_assert++;
    if (ram_rd_en_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_rmw_in_read: rd_en=%b, required 1", ram_rd_en_o);
    end
    #2 rst_i = 1'b0;
    #1;
    n_assert++;
    if ({req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, ram_rd_en_o, ram_rd_addr_o,
         ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o} !== '0) begin
      n_fail++; $display("FAIL rst_rmw_outputs: rd_en=%b wr_en=%b ready=%b, required all outputs 0",
                         ram_rd_en_o, ram_wr_en_o, req_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b1; #1;
    n_assert++;
    if (req_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_rmw_ready_early: ready=%b, required 0", req_ready_o);
    end
    @(posedge clk_i); #1;
    n_assert++;
    if (req_ready_o !== 1'b1 || rsp_cnt != rsp0 || wr_cnt != wr0) begin
      n_fail++; $display("FAIL rst_rmw_after: ready=%b rsp_pulses=%0d writes=%0d, required 1/%0d/%0d",
                         req_ready_o, rsp_cnt, wr_cnt, rsp0, wr0);
    end
    xact(1'b0, 2'b10, 1'b0, 32'h0020_0080, 32'h0, r, e);
    n_assert++;
    if (r.rdata !== 32'h5566_7788 || r.lat != 2 || r.err !== 1'b0) begin
      n_fail++; $display("FAIL rst_rmw_readback: rdata=%h lat=%0d, required 55667788/2", r.rdata, r.lat);
    end
  endtask

  task automatic test_random;
    res_t r, e;
    logic we, uns;
    logic [1:0] sz;
    logic [31:0] a, wd;
    int sel;
    for (int n = 0; n < 80; n++) begin
      we  = 1'($urandom);
      uns = 1'($urandom);
      sz  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      wd  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = ORI - 32'($urandom_range(1, 4));
      else if (sel == 1) a = ORI + LEN - 32'($urandom_range(0, 4));
      else begin
        a = ORI + 32'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 2'b01) a[0] = 1'b0;
          if (sz == 2'b10) a[1:0] = 2'b00;
        end
      end
      xact(we, sz, uns, a, wd, r, e);
      n_assert++;
      if (r.rdata !== e.rdata || r.err !== e.err) begin
        n_fail++; $display("FAIL rand_data[%0d] we=%b sz=%0d a=%h: rdata=%h err=%b, required %h err=%b",
                           n, we, sz, a, r.rdata, r.err, e.rdata, e.err);
      end
      n_assert++;
      if (r.lat != e.lat || r.nrd != e.nrd || r.nwr != e.nwr || r.both || r.busy_rdy || !r.pulse_ok) begin
        n_fail++; $display("FAIL rand_timing[%0d]: lat=%0d nrd=%0d nwr=%0d both=%b busyrdy=%b pulse=%b, required %0d/%0d/%0d/0/0/1",
                           n, r.lat, r.nrd, r.nwr, r.both, r.busy_rdy, r.pulse_ok, e.lat, e.nrd, e.nwr);
      end
      if (e.nwr == 1) begin
        n_assert++;
        if (r.wdata !== e.wdata || r.waddr !== e.waddr) begin
          n_fail++; $display("FAIL rand_write[%0d]: wdata=%h waddr=%h, required %h %h",
                             n, r.wdata, r.waddr, e.wdata, e.waddr);
        end
      end
      if (e.nrd == 1) begin
        n_assert++;
        if (r.raddr !== e.raddr) begin
          n_fail++; $display("FAIL rand_raddr[%0d]: raddr=%h, required %h", n, r.raddr, e.raddr);
        end
      end
    end
  endtask

  task automatic test_memory_image;
    int bad;
    bad = 0;
    for (int i = 0; i < 4096; i++) if (tmem[i] !== ref_mem[i]) bad++;
    n_assert++;
    if (bad != 0) begin
      n_fail++; $display("FAIL memory_image: %0d bytes differ from reference, required 0", bad);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_extension();
    test_rmw();
    test_word_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    test_memory_image();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
